// File: rtl/uart_frame_rx.sv
// UART frame receiver: 8 data bits LSB first, one parity bit, one stop bit.
// Define PARITY_CHECK_EN to flag even-parity mismatches on parity_err.
module uart_frame_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [8:0] frame,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          rx_s1_q, rx_s2_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] samp_q, samp_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [8:0]    frame_q, frame_d;
    logic          fv_q, fv_d;
    logic          fe_q, fe_d;
    logic          pe_q, pe_d;
    logic          busy_q, busy_d;

    logic          tick;
    logic          centre;
    logic [8:0]    frame_nxt;

    assign tick      = (tick_cnt_q == TICK_LAST);
    assign centre    = tick && (samp_q == SAMP_LAST);
    assign frame_nxt = {par_q, shift_q};

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        samp_d     = samp_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        frame_d    = frame_q;
        fv_d       = 1'b0;
        fe_d       = 1'b0;
        pe_d       = 1'b0;
        busy_d     = busy_q;

        if (tick && state_q != S_IDLE && state_q != S_BREAK) begin
            samp_d = (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                // Restart the bit clock so sampling phase follows the falling edge.
                if (!rx_s2_q) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    samp_d     = '0;
                end
            end
            S_START: begin
                if (tick && samp_q == SAMP_MID) begin
                    if (!rx_s2_q) begin
                        state_d    = S_DATA;
                        tick_cnt_d = '0;
                        samp_d     = '0;
                        bit_d      = '0;
                        busy_d     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (centre) begin
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (centre) begin
                    par_d   = rx_s2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (centre) begin
                    busy_d = 1'b0;
                    if (rx_s2_q) begin
                        frame_d = frame_nxt;
                        fv_d    = 1'b1;
`ifdef PARITY_CHECK_EN
                        pe_d    = ^frame_nxt;
`else
                        pe_d    = 1'b0;
`endif
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            tick_cnt_q <= '0;
            samp_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            frame_q    <= '0;
            fv_q       <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            tick_cnt_q <= tick_cnt_d;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            frame_q    <= frame_d;
            fv_q       <= fv_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            busy_q     <= busy_d;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign parity_err  = pe_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: vector table plus corner-case sequences,
// strobes checked against a scoreboard of expected frames.
module tb_uart_frame_rx;
    localparam int CLK_FREQ = 16_000_000;
    localparam int BAUD     = 250_000;
    localparam int OS       = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BIT      = DIV * OS;
    localparam int PERIOD   = 10;
    // 2-FF sync + edge detect, half a bit to start centre, 10 bits to stop centre.
    localparam int LAT      = 3 + (OS / 2) * DIV + 10 * BIT;
`ifdef PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [8:0] frame;
    logic       frame_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    always #(PERIOD / 2) clk = ~clk;

    uart_frame_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .frame      (frame),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         gap;
        logic [8:0] exp_frame;
        logic       exp_perr;
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [8:0] frame;
        logic       perr;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       sbq[$];
    time        strobe_t[$];
    time        t_start;
    logic [8:0] last_frame = '0;
    vec_t       vecs[5];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(logic is_err, logic [8:0] f, logic pe);
        exp_t e;
        e.is_err = is_err;
        e.frame  = f;
        e.perr   = pe;
        sbq.push_back(e);
    endtask

    task automatic drive_bit(logic b, int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(logic [7:0] d, logic p, logic s);
        t_start = $time;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) chk("busy_mid_frame", busy, 1);
            drive_bit(d[i], BIT);
        end
        drive_bit(p, BIT);
        drive_bit(s, BIT);
    endtask

    task automatic check_latency(int n_before, string name);
        chk({name, "_strobe_count"}, strobe_t.size(), n_before + 1);
        if (strobe_t.size() == n_before + 1)
            chk({name, "_latency"}, int'(strobe_t[n_before] - t_start),
                LAT * PERIOD);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (frame_valid || frame_err)) begin
            chk("strobe_exclusive", frame_valid & frame_err, 0);
            chk("busy_at_strobe", busy, 0);
            strobe_t.push_back($time);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: valid=%b err=%b frame=%h",
                         frame_valid, frame_err, frame);
            end else begin
                e = sbq.pop_front();
                chk("strobe_kind", frame_err, e.is_err);
                if (e.is_err) begin
                    chk("frame_hold", frame, last_frame);
                end else begin
                    chk("frame", frame, e.frame);
                    chk("parity_err", parity_err, e.perr);
                    last_frame = e.frame;
                end
            end
        end
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0] = '{8'hA5, 1'b0, 1, 9'h0A5, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1, 9'h001, PCHK};
        vecs[2] = '{8'h01, 1'b1, 1, 9'h101, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 1, 9'h13C, PCHK};
        vecs[4] = '{8'hC3, 1'b0, 2, 9'h0C3, 1'b0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_frame", frame, 0);
        chk("reset_valid", frame_valid, 0);
        chk("reset_err", frame_err, 0);
        chk("reset_perr", parity_err, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        drive_bit(1'b1, BIT);

        foreach (vecs[k]) begin
            n = strobe_t.size();
            push_exp(1'b0, vecs[k].exp_frame, vecs[k].exp_perr);
            send_frame(vecs[k].data, vecs[k].par, 1'b1);
            check_latency(n, "vec");
            chk("busy_after", busy, 0);
            drive_bit(1'b1, vecs[k].gap * BIT);
        end

        // Start glitch shorter than half a bit must be ignored.
        n = strobe_t.size();
        drive_bit(1'b0, 3 * DIV);
        drive_bit(1'b1, 2 * BIT);
        chk("glitch_no_strobe", strobe_t.size(), n);
        chk("glitch_busy", busy, 0);
        push_exp(1'b0, 9'h03C, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1);
        check_latency(n, "after_glitch");
        drive_bit(1'b1, BIT);

        // Bad stop bit then line held low: one error, no reframing.
        n = strobe_t.size();
        push_exp(1'b1, 9'h0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0);
        drive_bit(1'b0, BIT);
        chk("break_one_strobe", strobe_t.size(), n + 1);
        chk("break_busy", busy, 0);
        chk("break_frame_hold", frame, 9'h03C);
        drive_bit(1'b1, BIT);
        n = strobe_t.size();
        push_exp(1'b0, 9'h055, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1);
        check_latency(n, "after_break");
        drive_bit(1'b1, BIT);

        // Reset during data bit 4 aborts the frame silently.
        n = strobe_t.size();
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT);
        drive_bit(1'b0, BIT / 2);
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_frame", frame, 0);
        chk("rst_mid_valid", frame_valid, 0);
        chk("rst_mid_err", frame_err, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        last_frame = '0;
        drive_bit(1'b1, 2 * BIT);
        chk("rst_no_strobe", strobe_t.size(), n);
        push_exp(1'b0, 9'h081, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1);
        check_latency(n, "after_rst");
        drive_bit(1'b1, BIT);

        // Back-to-back frames with no idle bit between them.
        n = strobe_t.size();
        push_exp(1'b0, 9'h0FF, 1'b0);
        push_exp(1'b0, 9'h000, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b1);
        drive_bit(1'b1, BIT);
        chk("b2b_strobe_count", strobe_t.size(), n + 2);
        if (strobe_t.size() >= n + 2)
            chk("b2b_spacing", int'(strobe_t[n + 1] - strobe_t[n]),
                11 * BIT * PERIOD);

        for (int w = 0; w < 4 * BIT; w++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
